// File: rtl/fdct_row.sv
// fdct_row: forward HEVC integer DCT, row stage (4- or 8-point).
//
// A row arrives as one sample per accepted cycle. Eight accumulator lanes,
// one per coefficient k, do serial multiply-accumulate. When a row completes,
// the shifted and saturated lane results are captured into an output buffer.
// A two-state serializer then streams coefficient 0..N-1, one per cycle.
// The accumulators restart on the next row while the buffer drains.
//
// Ports:
//   clk, rst_n         clock and asynchronous active-low reset
//   in_valid, x_in     input sample strobe and signed sample
//   in_size            2'b01 = 4-point row, 2'b10 = 8-point row (read at n = 0)
//   out_valid, y_idx   output strobe and coefficient index
//   y_out              signed, saturated coefficient

// One accumulator lane. It preloads the rounding offset on the first sample
// of a row, and presents its result already shifted and saturated.
module fdct_row_lane #(
  parameter int WIDTH_X   = 16,
  parameter int WIDTH_Y   = 27,
  parameter int SHIFT_ROW = 2,
  parameter int ADD_ROW   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      first,
  input  logic signed [7:0]         coef,
  input  logic signed [WIDTH_X-1:0] x,
  output logic signed [WIDTH_X-1:0] y
);
  localparam logic signed [WIDTH_Y-1:0] SAT_MAX = WIDTH_Y'((2**(WIDTH_X-1)) - 1);
  localparam logic signed [WIDTH_Y-1:0] SAT_MIN = -SAT_MAX - WIDTH_Y'(1);

  logic signed [WIDTH_Y-1:0] acc, prod, base, sh;

  assign prod = WIDTH_Y'(coef) * WIDTH_Y'(x);
  assign base = first ? WIDTH_Y'(ADD_ROW) : acc;
  assign sh   = acc >>> SHIFT_ROW;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)  acc <= '0;
    else if (en) acc <= base + prod;

  always_comb begin
    y = sh[WIDTH_X-1:0];
    if (sh > SAT_MAX)      y = SAT_MAX[WIDTH_X-1:0];
    else if (sh < SAT_MIN) y = SAT_MIN[WIDTH_X-1:0];
  end
endmodule

module fdct_row #(
  parameter int WIDTH_X   = 16,
  parameter int WIDTH_Y   = 27,
  parameter int SHIFT_ROW = 2,
  parameter int ADD_ROW   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [1:0]                in_size,
  input  logic signed [WIDTH_X-1:0] x_in,
  output logic                      out_valid,
  output logic [2:0]                y_idx,
  output logic signed [WIDTH_X-1:0] y_out
);
  localparam int NUM_LANES = 8;
  localparam int STAGES    = 1;

  // First half (n = 0..3) of the 8-point matrix. The second half mirrors it,
  // negated on odd rows.
  localparam logic signed [7:0] C8_HALF [8][4] = '{
    '{ 8'sd64,  8'sd64,  8'sd64,  8'sd64},
    '{ 8'sd89,  8'sd75,  8'sd50,  8'sd18},
    '{ 8'sd83,  8'sd36, -8'sd36, -8'sd83},
    '{ 8'sd75, -8'sd18, -8'sd89, -8'sd50},
    '{ 8'sd64, -8'sd64, -8'sd64,  8'sd64},
    '{ 8'sd50, -8'sd89,  8'sd18,  8'sd75},
    '{ 8'sd36, -8'sd83,  8'sd83, -8'sd36},
    '{ 8'sd18, -8'sd50,  8'sd75, -8'sd89}
  };

  function automatic logic [7:0] c8(input logic [2:0] k, input logic [2:0] nn);
    logic [1:0]        m;
    logic signed [7:0] c;
    m = nn[2] ? ~nn[1:0] : nn[1:0];   // 7-n for the mirrored half
    c = C8_HALF[k][m];
    return (nn[2] && k[0]) ? -c : c;
  endfunction

  typedef enum logic {IDLE, SEND} ser_state_t;

  logic [2:0]  n;
  logic [1:0]  rsize, eff_size;
  logic        accept, is8, last, first;
  logic [STAGES:0] vld_pipe;        // [0]: last sample accepted; [STAGES]: buffer load
  logic [NUM_LANES-1:0][7:0]         coef;
  logic [NUM_LANES-1:0][WIDTH_X-1:0] sat_y, obuf;
  logic        bsize8;
  ser_state_t  state, state_d;
  logic [2:0]  j, j_d;

  // The size comes straight from in_size at row start and from the latched
  // copy afterwards, so mid-row changes on in_size have no effect.
  assign eff_size = (n == 3'd0) ? in_size : rsize;
  assign is8      = (eff_size == 2'b10);
  assign accept   = in_valid && (eff_size == 2'b01 || eff_size == 2'b10);
  assign first    = (n == 3'd0);
  assign last     = is8 ? (n == 3'd7) : (n == 3'd3);
  assign vld_pipe[0] = accept && last;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n     <= '0;
      rsize <= '0;
      vld_pipe[STAGES:1] <= '0;
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (accept) begin
        n <= last ? 3'd0 : n + 3'd1;
        if (first) rsize <= in_size;
      end
    end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    // A 4-point row uses the even rows of the 8-point matrix. Upper lanes idle.
    if (k < 4) begin : g_lo
      assign coef[k] = is8 ? c8(3'(k), n) : c8(3'(2*k), n);
    end else begin : g_hi
      assign coef[k] = is8 ? c8(3'(k), n) : 8'd0;
    end
    fdct_row_lane #(
      .WIDTH_X(WIDTH_X), .WIDTH_Y(WIDTH_Y), .SHIFT_ROW(SHIFT_ROW), .ADD_ROW(ADD_ROW)
    ) u_lane (
      .clk(clk), .rst_n(rst_n), .en(accept), .first(first),
      .coef(coef[k]), .x(x_in), .y(sat_y[k])
    );
  end

  // The buffer load reads the old accumulator values. On the same edge the
  // lanes may already preload for the next row.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      obuf   <= '0;
      bsize8 <= 1'b0;
    end else if (vld_pipe[STAGES]) begin
      obuf   <= sat_y;
      bsize8 <= (rsize == 2'b10);
    end

  always_comb begin
    state_d = state;
    j_d     = j;
    if (vld_pipe[STAGES]) begin
      state_d = SEND;
      j_d     = 3'd0;
    end else if (state == SEND) begin
      j_d = j + 3'd1;
      if (j == (bsize8 ? 3'd7 : 3'd3)) begin
        state_d = IDLE;
        j_d     = 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      j         <= '0;
      out_valid <= 1'b0;
      y_idx     <= '0;
      y_out     <= '0;
    end else begin
      state     <= state_d;
      j         <= j_d;
      out_valid <= (state == SEND);
      y_idx     <= (state == SEND) ? j : 3'd0;
      if (state == SEND) y_out <= obuf[j];
    end
endmodule

// File: tb/tb_fdct_row.sv
// Scoreboard bench for fdct_row. Directed rows push hand-computed coefficients
// into a queue. A negedge monitor pops and compares on every out_valid.
module tb_fdct_row;
  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic [1:0]         in_size;
  logic signed [15:0] x_in;
  logic               out_valid;
  logic [2:0]         y_idx;
  logic signed [15:0] y_out;

  fdct_row dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_size(in_size),
    .x_in(x_in), .out_valid(out_valid), .y_idx(y_idx), .y_out(y_out)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int val; } exp_t;
  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   xv[8];
  int   ev[8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Monitor: every out_valid beat must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output idx=%0d val=%0d", y_idx, y_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk($sformatf("coef_idx%0d", e.idx), int'(y_idx), e.idx);
        chk($sformatf("coef_val%0d", e.idx), int'(y_out), e.val);
      end
    end
  end

  task automatic push_exp(input int nn);
    for (int k = 0; k < nn; k++) q.push_back('{k, ev[k]});
  endtask

  // Drive one row of xv. Optionally insert idle cycles before samples 2 and 5,
  // and scramble in_size after sample 0.
  task automatic run_row(input logic [1:0] sz, input int nn, input bit gaps, input bit toggle);
    for (int i = 0; i < nn; i++) begin
      if (gaps && (i == 2 || i == 5)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_size  = 2'b11;
      end
      @(negedge clk);
      in_valid = 1'b1;
      x_in     = 16'(xv[i]);
      in_size  = (i == 0 || !toggle) ? sz : ((i % 2) ? 2'b01 : 2'b00);
    end
  endtask

  task automatic idle(input int c);
    for (int i = 0; i < c; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      x_in     = 16'sd0;
    end
  endtask

  task automatic drain;
    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    chk("drain_queue_empty", q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_size = 2'b00; x_in = 16'sd0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_y_idx", int'(y_idx), 0);
    chk("rst_y_out", int'(y_out), 0);
    rst_n = 1'b1;

    // 8-point DC, with explicit out_valid timing
    xv = '{100, 100, 100, 100, 100, 100, 100, 100};
    ev = '{12800, 0, 0, 0, 0, 0, 0, 0};
    push_exp(8);
    run_row(2'b10, 8, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b0;          // after edge E
    @(negedge clk);                           // after E+1
    chk("dc8_lat_low", int'(out_valid), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("dc8_valid_%0d", i), int'(out_valid), 1);
    end
    @(negedge clk);
    chk("dc8_valid_end", int'(out_valid), 0);
    chk("dc8_idx_zero", int'(y_idx), 0);
    idle(2);

    // 4-point DC
    xv = '{100, 100, 100, 100, 0, 0, 0, 0};
    ev = '{6400, 0, 0, 0, 0, 0, 0, 0};
    push_exp(4);
    run_row(2'b01, 4, 1'b0, 1'b0);

    // Back-to-back: impulse, then positive and negative saturation
    xv = '{1000, 0, 0, 0, 0, 0, 0, 0};
    ev = '{16000, 22250, 20750, 18750, 16000, 12500, 9000, 4500};
    push_exp(8);
    run_row(2'b10, 8, 1'b0, 1'b0);
    xv = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
    ev = '{32767, 0, 0, 0, 0, 0, 0, 0};
    push_exp(8);
    run_row(2'b10, 8, 1'b0, 1'b0);
    xv = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
    ev = '{-32768, 0, 0, 0, 0, 0, 0, 0};
    push_exp(8);
    run_row(2'b10, 8, 1'b0, 1'b0);
    idle(1);

    // in_size = 00 at row start: nothing accepted
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_size = 2'b00; x_in = 16'sd5000;
    end

    // Mixed: 4-point row, then 8-point row with gaps and in_size scrambled
    xv = '{10, 20, 30, 40, 0, 0, 0, 0};
    ev = '{1600, -712, 0, -62, 0, 0, 0, 0};
    push_exp(4);
    run_row(2'b01, 4, 1'b0, 1'b0);
    xv = '{0, 0, 0, 0, 0, 0, 0, 1000};
    ev = '{16000, -22250, 20750, -18750, 16000, -12500, 9000, -4500};
    push_exp(8);
    run_row(2'b10, 8, 1'b1, 1'b1);
    idle(1);
    drain();
    idle(3);
    chk("idle_idx_zero", int'(y_idx), 0);

    // Mid-row reset: 5 samples, then async reset
    xv = '{100, 100, 100, 100, 100, 100, 100, 100};
    run_row(2'b10, 5, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", int'(out_valid), 0);
    chk("mrst_y_out", int'(y_out), 0);
    chk("mrst_y_idx", int'(y_idx), 0);
    q.delete();
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ev = '{12800, 0, 0, 0, 0, 0, 0, 0};
    push_exp(8);
    run_row(2'b10, 8, 1'b0, 1'b0);
    idle(1);
    drain();
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=timeout required=finish");
    $fatal(1, "timeout");
  end
endmodule
